dpram_host_master: RTL

DPRAM_HOST_MASTER -- requirements
Module: dpram_host_master

---
 rtl/dpram_host_master.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dpram_host_master.sv
// Port-1 initiator for the shared DPRAM multiply block.
// Sequence: write A and B, set start, poll STATUS, read Y, clear CONTROL.
module dpram_host_master #(
  parameter int unsigned POLL_LIMIT   = 256,
  parameter logic [3:0]  ADDR_CONTROL = 4'h0,
  parameter logic [3:0]  ADDR_STATUS  = 4'h1,
  parameter logic [3:0]  ADDR_A       = 4'h2,
  parameter logic [3:0]  ADDR_B       = 4'h3,
  parameter logic [3:0]  ADDR_Y       = 4'h4
) (
  input  logic        clk_i,
  input  logic        rst_i_n,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] y_o,
  output logic [3:0]  dpram_s1_addr_o,
  output logic        dpram_s1_clken_o,
  output logic        dpram_s1_write_en_o,
  output logic [31:0] dpram_s1_writedata_o,
  input  logic [31:0] dpram_s1_readdata_i
);

  typedef enum logic [3:0] {
    IDLE,
    WR_A,
    WR_B,
    WR_CTRL,
    POLL_RD,
    POLL_CHK,
    RD_Y,
    RD_Y_CAP,
    CLR_CTRL,
    DONE,
    ABORT
  } state_t;

  localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

  state_t      state;
  logic [31:0] b_q;
  logic [15:0] poll_cnt;

  // A needs no separate holding register: the write-data register captures it
  // on the start edge and presents it during WR_A.
  always_ff @(posedge clk_i) begin
    if (!rst_i_n) begin
      state                <= IDLE;
      b_q                  <= '0;
      poll_cnt             <= '0;
      busy_o               <= 1'b0;
      done_o               <= 1'b0;
      timeout_o            <= 1'b0;
      y_o                  <= '0;
      dpram_s1_addr_o      <= '0;
      dpram_s1_clken_o     <= 1'b0;
      dpram_s1_write_en_o  <= 1'b0;
      dpram_s1_writedata_o <= '0;
    end else begin
      // NOTE: outputs are registered, so each branch loads the bus values that
      // belong to the state being entered; these defaults return the bus to 0.
      dpram_s1_addr_o      <= '0;
      dpram_s1_clken_o     <= 1'b0;
      dpram_s1_write_en_o  <= 1'b0;
      dpram_s1_writedata_o <= '0;
      done_o               <= 1'b0;
      timeout_o            <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            b_q                  <= b_i;
            poll_cnt             <= '0;
            busy_o               <= 1'b1;
            state                <= WR_A;
            dpram_s1_clken_o     <= 1'b1;
            dpram_s1_write_en_o  <= 1'b1;
            dpram_s1_addr_o      <= ADDR_A;
            dpram_s1_writedata_o <= a_i;
          end
        end

        WR_A: begin
          state                <= WR_B;
          dpram_s1_clken_o     <= 1'b1;
          dpram_s1_write_en_o  <= 1'b1;
          dpram_s1_addr_o      <= ADDR_B;
          dpram_s1_writedata_o <= b_q;
        end

        WR_B: begin
          state                <= WR_CTRL;
          dpram_s1_clken_o     <= 1'b1;
          dpram_s1_write_en_o  <= 1'b1;
          dpram_s1_addr_o      <= ADDR_CONTROL;
          dpram_s1_writedata_o <= 32'h1;
        end

        WR_CTRL: begin
          state            <= POLL_RD;
          dpram_s1_clken_o <= 1'b1;
          dpram_s1_addr_o  <= ADDR_STATUS;
        end

        POLL_RD: begin
          // Read data arrives one cycle after the access; check it next.
          state <= POLL_CHK;
        end

        POLL_CHK: begin
          if (dpram_s1_readdata_i[0]) begin
            state            <= RD_Y;
            dpram_s1_clken_o <= 1'b1;
            dpram_s1_addr_o  <= ADDR_Y;
          end else if (poll_cnt == POLL_LAST) begin
            state                <= ABORT;
            timeout_o            <= 1'b1;
            dpram_s1_clken_o     <= 1'b1;
            dpram_s1_write_en_o  <= 1'b1;
            dpram_s1_addr_o      <= ADDR_CONTROL;
            dpram_s1_writedata_o <= 32'h0;
          end else begin
            poll_cnt         <= poll_cnt + 16'd1;
            state            <= POLL_RD;
            dpram_s1_clken_o <= 1'b1;
            dpram_s1_addr_o  <= ADDR_STATUS;
          end
        end

        RD_Y: begin
          state <= RD_Y_CAP;
        end

        RD_Y_CAP: begin
          y_o                  <= dpram_s1_readdata_i;
          state                <= CLR_CTRL;
          dpram_s1_clken_o     <= 1'b1;
          dpram_s1_write_en_o  <= 1'b1;
          dpram_s1_addr_o      <= ADDR_CONTROL;
          dpram_s1_writedata_o <= 32'h0;
        end

        CLR_CTRL: begin
          state  <= DONE;
          done_o <= 1'b1;
        end

        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        ABORT: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
